// File: rtl/ysyx_24100027_ifu_seq.sv
// ---------------------------------------------------------------------------
// ysyx_24100027_ifu_seq
//
// Multi-cycle instruction sequencer. Owns the PC, fetches one instruction at a
// time over a valid/ready request + valid response memory port, holds the
// fetched word for decode and raises a single-cycle execute strobe. Handles
// PC redirect, ebreak halt, and fetch fault (error response or timeout).
//
// Ports:
//   clk, rst           clock (rising edge) / asynchronous active-low reset
//   imem_req_valid     fetch request valid (only in FETCH)
//   imem_req_ready     memory accepts the request
//   imem_req_addr      fetch address, always equal to pc
//   imem_resp_valid    response valid (only consumed in WAIT)
//   imem_resp_data     instruction word
//   imem_resp_err      access fault, qualified by imem_resp_valid
//   pc                 PC of the instruction in flight
//   inst               latched instruction for IMM/IDU/GPR
//   exec               one-cycle execute strobe
//   wen_gate           AND-mask for GPR write enable
//   redirect_valid/pc  taken branch/jump and its target, sampled in EXEC
//   halt_req           ebreak decoded, sampled in EXEC
//   halted, fault      sticky terminal status, cleared only by reset
//   retire_cnt         retired-instruction counter (wraps at 2^32)
// ---------------------------------------------------------------------------
module ysyx_24100027_ifu_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        exec,
  output logic        wen_gate,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // The wait counter counts completed WAIT cycles without a response. When
  // it already holds TIMEOUT-1, the current cycle is the TIMEOUT-th silent
  // cycle, so a missing response there is the fault point, while a response
  // arriving in that same cycle is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] inst_next;
  logic [31:0] retire_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_next;
  logic        misaligned;

  // Status and strobes are pure functions of the state, so HALT and FAULT
  // automatically silence every strobe.
  assign imem_req_valid = (state == S_FETCH);
  assign imem_req_addr  = pc;
  assign exec           = (state == S_EXEC);
  assign halted         = (state == S_HALT);
  assign fault          = (state == S_FAULT);

  // A misaligned redirect target only matters when the redirect is actually
  // taken; a simultaneous halt request wins and the redirect is ignored.
  assign misaligned = exec && redirect_valid && !halt_req &&
                      (redirect_pc[1:0] != 2'b00);
  assign wen_gate   = exec && !misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      retire_cnt <= 32'd0;
      wait_cnt   <= 8'd0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      inst       <= inst_next;
      retire_cnt <= retire_next;
      wait_cnt   <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    inst_next     = inst;
    retire_next   = retire_cnt;
    wait_cnt_next = wait_cnt;

    case (state)
      S_FETCH: begin
        // Address is the registered pc, so it cannot move while stalled.
        if (imem_req_ready) begin
          state_next    = S_WAIT;
          wait_cnt_next = 8'd0;
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_next = S_FAULT;
          end else begin
            inst_next  = imem_resp_data;
            state_next = S_EXEC;
          end
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LAST) begin
            state_next = S_FAULT;
          end
        end
      end

      S_EXEC: begin
        if (halt_req) begin
          retire_next = retire_cnt + 32'd1;
          state_next  = S_HALT;
        end else if (redirect_valid) begin
          if (misaligned) begin
            state_next = S_FAULT;
          end else begin
            retire_next = retire_cnt + 32'd1;
            pc_next     = redirect_pc;
            state_next  = S_FETCH;
          end
        end else begin
          retire_next = retire_cnt + 32'd1;
          pc_next     = pc + 32'd4;
          state_next  = S_FETCH;
        end
      end

      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;

      // Unused encodings recover to a fresh fetch.
      default: state_next = S_FETCH;
    endcase
  end

endmodule
